// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and scan-code constants for the PS/2 key event path
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRE_E0,
      ST_PRE_F0,
      ST_PRE_E0F0
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

   // Keyboard housekeeping bytes (errors, BAT result, ACK, resend) never form a key event.
   function automatic logic is_sys_code(input logic [7:0] b);
      return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous FIFO; a push into a full FIFO succeeds only alongside a pop
module ps2_event_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count_nxt,
   output logic                   drop
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      empty     = (count == '0);
      full      = (count == (AW+1)'(DEPTH));
      do_pop    = pop & ~empty;
      do_push   = push & (~full | do_pop);
      drop      = push & ~do_push;
      count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      head_data = empty ? '0 : mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// rtl/ps2_key_event_ctrl.sv - folds E0/F0 prefixes into key events, queues them, tracks errors
module ps2_key_event_ctrl
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic [7:0]       rx_byte,
   input  logic             rx_parity_err,
   input  logic             ev_ready,
   input  logic             clr_err,
   output logic             ev_valid,
   output logic [9:0]       ev_data,
   output logic             kbd_inhibit,
   output logic             err_parity,
   output logic             err_timeout,
   output logic             overflow,
   output logic [CNT_W-1:0] err_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]    TMAX    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   ps2_state_t       state;
   ps2_state_t       state_nxt;
   logic [TW-1:0]    timer;
   logic             push;
   ps2_event_t       push_ev;
   logic             parity_hit;
   logic             timeout_hit;
   logic             drop;
   logic             fifo_empty;
   logic [AW:0]      count_nxt;
   logic [1:0]       err_inc;
   logic [CNT_W-1:0] err_base;
   logic [CNT_W+1:0] err_sum;

   always_comb begin
      state_nxt   = state;
      push        = 1'b0;
      push_ev     = '0;
      parity_hit  = 1'b0;
      timeout_hit = 1'b0;
      if (rx_valid) begin
         if (rx_parity_err) begin
            parity_hit = 1'b1;
            state_nxt  = ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rx_byte == PS2_EXT)      state_nxt = ST_PRE_E0;
                  else if (rx_byte == PS2_BRK) state_nxt = ST_PRE_F0;
                  else if (!is_sys_code(rx_byte)) begin
                     push    = 1'b1;
                     push_ev = '{ext: 1'b0, brk: 1'b0, code: rx_byte};
                  end
               end
               ST_PRE_E0: begin
                  if (rx_byte == PS2_BRK)      state_nxt = ST_PRE_E0F0;
                  else if (rx_byte != PS2_EXT) begin
                     push      = 1'b1;
                     push_ev   = '{ext: 1'b1, brk: 1'b0, code: rx_byte};
                     state_nxt = ST_IDLE;
                  end
               end
               default: begin
                  // A stray prefix after F0 starts a fresh sequence instead of being emitted.
                  if (rx_byte == PS2_EXT)      state_nxt = ST_PRE_E0;
                  else if (rx_byte == PS2_BRK) state_nxt = ST_PRE_F0;
                  else begin
                     push      = 1'b1;
                     push_ev   = '{ext: (state == ST_PRE_E0F0), brk: 1'b1, code: rx_byte};
                     state_nxt = ST_IDLE;
                  end
               end
            endcase
         end
      end else if (state != ST_IDLE && timer == TMAX) begin
         timeout_hit = 1'b1;
         state_nxt   = ST_IDLE;
      end

      err_inc  = {1'b0, parity_hit} + {1'b0, timeout_hit} + {1'b0, drop};
      err_base = clr_err ? '0 : err_count;
      err_sum  = (CNT_W+2)'(err_base) + (CNT_W+2)'(err_inc);
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (10)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_ev),
      .pop       (ev_ready),
      .head_data (ev_data),
      .empty     (fifo_empty),
      .count_nxt (count_nxt),
      .drop      (drop)
   );

   assign ev_valid = ~fifo_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         timer       <= '0;
         kbd_inhibit <= 1'b0;
         err_parity  <= 1'b0;
         err_timeout <= 1'b0;
         overflow    <= 1'b0;
         err_count   <= '0;
      end else begin
         state       <= state_nxt;
         timer       <= (state_nxt == ST_IDLE || rx_valid) ? '0 : timer + 1'b1;
         kbd_inhibit <= (count_nxt >= (AW+1)'(FIFO_DEPTH - 1));
         err_parity  <= parity_hit;
         err_timeout <= timeout_hit;
         if (drop)         overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;
         err_count <= (err_sum > (CNT_W+2)'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];
      end
   end

endmodule
